multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the RV32 subset datapath (R-type, I-type ALU, lw, sw, beq). It replaces the combinational `control` decode with a state machine. A single shared instruction/data memory and a single ALU are reused across cycles, and the block stalls on a memory ready handshake. It sits beside the datapath, reads the instruction register opcode and the ALU zero flag, and drives every enable and mux select.

## Interface
- RETIRED_WIDTH, 32, width of the retired-instruction counter
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  IR[6:0], held stable by the datapath between irWrite pulses
- aluZero  in  1  ALU zero flag, valid in the same cycle
- memReady  in  1  memory completes the current read/write this cycle
- pcWrite  out  1  load PC this edge
- irWrite  out  1  load IR and oldPC this edge
- iorD  out  1  memory address: 0=PC, 1=ALUOut
- memRead, memWrite  out  1 each  memory strobes
- memtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- regWrite  out  1  register file write enable
- aluSrcA  out  2  00=PC, 01=oldPC, 10=regA
- aluSrcB  out  2  00=regB, 01=constant 4, 10=imm
- aluOp  out  2  00=add, 01=sub, 10=funct-decoded (to aluControl)
- pcSource  out  1  PC input: 0=ALU result, 1=ALUOut
- halted  out  1  high in HALT
- retired  out  RETIRED_WIDTH  instructions completed
- state  out  4  current state encoding (debug)

## Operation
- States and encoding: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, HALT=9. Codes 10–15 are illegal and go to HALT.
- Outputs are Moore-decoded from `state`. The only exceptions are pcWrite and irWrite, which are gated by the same-cycle memReady/aluZero. Any output not listed for a state is 0.
- FETCH: memRead=1, iorD=0, aluSrcA=00, aluSrcB=01, aluOp=00, pcSource=0. When memReady=1, irWrite=1 and pcWrite=1, and the next state is DECODE; otherwise the block stays in FETCH.
- DECODE computes the branch target, oldPC+imm, into ALUOut (aluSrcA=01, aluSrcB=10, aluOp=00). Next state by opcode:
  - 0110011 or 0010011 -> EXECUTE
  - 0000011 or 0100011 -> MEMADDR
  - 1100011 -> BRANCH
  - any other value -> HALT
- EXECUTE: aluSrcA=10, aluOp=10. aluSrcB=00 for R-type, 10 for I-type. Next state ALUWB.
- ALUWB: regWrite=1, memtoReg=0. Next state FETCH.
- MEMADDR: aluSrcA=10, aluSrcB=10, aluOp=00. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: memRead=1, iorD=1. Moves to MEMWB when memReady=1, else holds.
- MEMWB: regWrite=1, memtoReg=1. Next state FETCH.
- MEMWRITE: memWrite=1, iorD=1. Moves to FETCH when memReady=1, else holds with memWrite held high.
- BRANCH: aluSrcA=10, aluSrcB=00, aluOp=01, pcSource=1, pcWrite=aluZero. Next state FETCH.
- HALT: all strobes 0, halted=1. Only reset leaves HALT.
- retired increments by 1 on the last cycle of each instruction and wraps modulo 2^RETIRED_WIDTH. Last cycles are:
  - ALUWB
  - MEMWB
  - MEMWRITE with memReady=1
  - BRANCH
- Illegal opcodes do not increment retired.

## Timing
- Reset, asynchronous and active-high:
  - state=FETCH, retired=0, halted=0.
  - While reset is high, pcWrite, irWrite, regWrite and memWrite are forced 0.
- After reset deasserts, the FETCH decode applies: memRead=1, aluSrcB=01, all other outputs 0 until memReady.
- Cycle counts with memReady held at 1:
  - R/I-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
- Each memReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- memReady is ignored in all other states.
- Reset asserted mid-instruction aborts the instruction with no further register or memory write.
- A memReady pulse in a non-memory state has no effect.

## Test plan
- Reset, then memReady=1, opcode=0010011 -> state sequence 0,1,6,7,0. pcWrite and irWrite high in cycle 0 only. regWrite high in cycle 3 only. retired=1 after the 4th edge.
- lw (0000011) with memReady low for 2 cycles in FETCH and 3 cycles in MEMREAD -> total 10 cycles. iorD=1 only in MEMREAD. memtoReg=1 and regWrite=1 only in MEMWB.
- beq (1100011) -> BRANCH with aluOp=01 and pcSource=1. With aluZero=1, pcWrite=1; with aluZero=0, pcWrite=0. retired increments in both cases.
- sw (0100011) with memReady=0 for 2 cycles in MEMWRITE -> memWrite stays high for 3 cycles. FETCH follows. regWrite is never asserted.
- opcode=1111111 in DECODE -> HALT, halted=1, all strobes 0 for 20 cycles, retired unchanged. Reset -> FETCH and halted=0.
- Reset asserted asynchronously during MEMWRITE, between edges -> memWrite drops immediately, state=0, retired=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32 subset datapath (R/I-type ALU, lw, sw, beq).
// Drives every datapath enable and mux select and stalls on the memory ready handshake.
module multicycle_control #(
  parameter int unsigned RETIRED_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [6:0]               opcode,
  input  logic                     aluZero,
  input  logic                     memReady,
  output logic                     pcWrite,
  output logic                     irWrite,
  output logic                     iorD,
  output logic                     memRead,
  output logic                     memWrite,
  output logic                     memtoReg,
  output logic                     regWrite,
  output logic [1:0]               aluSrcA,
  output logic [1:0]               aluSrcB,
  output logic [1:0]               aluOp,
  output logic                     pcSource,
  output logic                     halted,
  output logic [RETIRED_WIDTH-1:0] retired,
  output logic [3:0]               state
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   retire_c;

  // State register and retired-instruction counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) retired <= retired + RETIRED_WIDTH'(1);
    end
  end

  // Next-state and Moore output decode; pcWrite/irWrite gated by same-cycle inputs
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    iorD     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memtoReg = 1'b0;
    regWrite = 1'b0;
    aluSrcA  = 2'b00;
    aluSrcB  = 2'b00;
    aluOp    = 2'b00;
    pcSource = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        case (opcode)
          OP_R, OP_I:   state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_HALT;
        endcase
      end
      S_EXECUTE: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        aluSrcB = (opcode == OP_R) ? 2'b00 : 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMADDR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memtoReg = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReady) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_BRANCH: begin
        aluSrcA  = 2'b10;
        aluOp    = 2'b01;
        pcSource = 1'b1;
        pcWrite  = aluZero;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_HALT;
    endcase
    // Architectural write strobes never fire while reset is held
    if (reset) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      memWrite = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level sequence model
// checked every cycle, plus directed literal expectations.
module tb_multicycle_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic        aluZero = 1'b0;
  logic        memReady = 1'b0;
  logic        pcWrite, irWrite, iorD, memRead, memWrite, memtoReg, regWrite;
  logic [1:0]  aluSrcA, aluSrcB, aluOp;
  logic        pcSource, halted;
  logic [31:0] retired;
  logic [3:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control #(.RETIRED_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .aluZero(aluZero),
    .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .memtoReg(memtoReg),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .halted(halted), .retired(retired), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instruction class walks a fixed list of state codes;
  // memory states hold until memReady, finishing the list retires the instruction.
  int m_cls = 0;
  int m_idx = 0;
  logic [31:0] m_ret = '0;

  function automatic logic [3:0] code_of(input int c, input int i);
    logic [19:0] s;
    case (c)
      0:       s = {4'd0, 4'd7, 4'd6, 4'd1, 4'd0};
      1:       s = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      2:       s = {4'd0, 4'd5, 4'd2, 4'd1, 4'd0};
      3:       s = {4'd0, 4'd0, 4'd8, 4'd1, 4'd0};
      default: s = {4'd0, 4'd0, 4'd9, 4'd1, 4'd0};
    endcase
    return s[i*4 +: 4];
  endfunction

  function automatic int len_of(input int c);
    case (c)
      1:       return 5;
      0, 2:    return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int classify(input logic [6:0] op);
    if (op == OP_R || op == OP_I) return 0;
    if (op == OP_LW) return 1;
    if (op == OP_SW) return 2;
    if (op == OP_BEQ) return 3;
    return 4;
  endfunction

  always @(posedge clock or posedge reset) begin
    logic [3:0] c;
    logic adv;
    if (reset) begin
      m_idx = 0; m_cls = 0; m_ret = '0;
    end else begin
      c = code_of(m_cls, m_idx);
      adv = 1'b0;
      case (c)
        4'd0: if (memReady) m_idx = 1;
        4'd1: begin m_cls = classify(opcode); m_idx = 2; end
        4'd9: ;
        4'd3, 4'd5: adv = memReady;
        default: adv = 1'b1;
      endcase
      if (adv) begin
        if (m_idx == len_of(m_cls) - 1) begin
          m_idx = 0; m_ret = m_ret + 32'd1;
        end else m_idx = m_idx + 1;
      end
    end
  end

  // Expected control word: {pcW,irW,iorD,memRd,memWr,memtoReg,regW,srcA,srcB,aluOp,pcSrc,halted,state}
  function automatic logic [18:0] expect_word(input logic [3:0] c, input logic [6:0] op,
                                              input logic mr, input logic az, input logic rst);
    logic pw, iw, io, mrd, mwr, m2r, rw, ps, h;
    logic [1:0] sa, sb, ao;
    {pw, iw, io, mrd, mwr, m2r, rw, ps, h} = '0;
    sa = 2'b00; sb = 2'b00; ao = 2'b00;
    case (c)
      4'd0: begin mrd = 1; sb = 2'b01; pw = mr; iw = mr; end
      4'd1: begin sa = 2'b01; sb = 2'b10; end
      4'd2: begin sa = 2'b10; sb = 2'b10; end
      4'd3: begin mrd = 1; io = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; io = 1; end
      4'd6: begin sa = 2'b10; ao = 2'b10; sb = (op == OP_R) ? 2'b00 : 2'b10; end
      4'd7: rw = 1;
      4'd8: begin sa = 2'b10; ao = 2'b01; ps = 1; pw = az; end
      default: h = 1;
    endcase
    if (rst) begin pw = 0; iw = 0; rw = 0; mwr = 0; end
    return {pw, iw, io, mrd, mwr, m2r, rw, sa, sb, ao, ps, h, c};
  endfunction

  always @(negedge clock) begin
    chk("ctrl_word",
        32'({pcWrite, irWrite, iorD, memRead, memWrite, memtoReg, regWrite,
             aluSrcA, aluSrcB, aluOp, pcSource, halted, state}),
        32'(expect_word(code_of(m_cls, m_idx), opcode, memReady, aluZero, reset)));
    chk("retired", retired, m_ret);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_until(input logic [3:0] code);
    int n;
    n = 0;
    while (state != code && n < 50) begin tick(); n++; end
    if (state != code) begin
      n_cmp++; n_err++;
      $display("FAIL timeout waiting for state %0d, got %0d", code, state);
    end
  endtask

  logic [6:0]  ops [4];
  logic [31:0] saved;
  int cycles, fw, mw, wcnt;

  initial begin
    ops[0] = OP_BEQ; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_R;
    reset = 1; memReady = 1; opcode = '0; aluZero = 0;
    repeat (2) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pcwrite", 32'(pcWrite), 0);
    chk("rst_irwrite", 32'(irWrite), 0);
    chk("rst_memread", 32'(memRead), 1);

    // I-type with memReady high: 0,1,6,7,0
    reset = 0; opcode = OP_I; #1;
    chk("i_c0_pcwrite", 32'(pcWrite), 1);
    chk("i_c0_irwrite", 32'(irWrite), 1);
    tick(); chk("i_c1_state", 32'(state), 1); chk("i_c1_pcwrite", 32'(pcWrite), 0);
    tick(); chk("i_c2_state", 32'(state), 6); chk("i_c2_srcb", 32'(aluSrcB), 2);
    tick(); chk("i_c3_state", 32'(state), 7); chk("i_c3_regwrite", 32'(regWrite), 1);
    tick(); chk("i_c4_state", 32'(state), 0); chk("i_retired", retired, 1);

    // R-type uses regB as ALU operand
    opcode = OP_R;
    tick(); tick();
    chk("r_srcb", 32'(aluSrcB), 0); chk("r_aluop", 32'(aluOp), 2);
    tick(); tick();
    chk("r_retired", retired, 2);

    // lw with 2 fetch stalls and 3 read stalls
    opcode = OP_LW; fw = 0; mw = 0; cycles = 0; saved = retired;
    while (retired == saved && cycles < 40) begin
      memReady = !((state == 4'd0 && fw < 2) || (state == 4'd3 && mw < 3));
      if (!memReady && state == 4'd0) fw++;
      if (!memReady && state == 4'd3) mw++;
      tick(); cycles++;
    end
    memReady = 1;
    chk("lw_cycles", 32'(cycles), 10);
    chk("lw_state", 32'(state), 0);
    chk("lw_retired", retired, 3);

    // beq taken, then not taken with a stray memReady low
    opcode = OP_BEQ; aluZero = 1;
    tick(); tick();
    chk("beq_t_state", 32'(state), 8);
    chk("beq_t_pcwrite", 32'(pcWrite), 1);
    chk("beq_aluop", 32'(aluOp), 1);
    chk("beq_pcsource", 32'(pcSource), 1);
    tick(); chk("beq_t_retired", retired, 4);
    aluZero = 0;
    tick(); tick();
    chk("beq_nt_pcwrite", 32'(pcWrite), 0);
    memReady = 0;
    tick();
    chk("beq_nt_state", 32'(state), 0);
    chk("beq_nt_retired", retired, 5);
    memReady = 1;

    // sw with 2 write stalls: memWrite high 3 cycles
    opcode = OP_SW; wcnt = 0;
    tick(); tick(); tick();
    chk("sw_state", 32'(state), 5);
    memReady = 0;
    if (memWrite) wcnt++; tick();
    if (memWrite) wcnt++; tick();
    memReady = 1;
    if (memWrite) wcnt++; tick();
    chk("sw_memwrite_cycles", 32'(wcnt), 3);
    chk("sw_next_state", 32'(state), 0);
    chk("sw_retired", retired, 6);

    // Mixed instructions with irregular memReady/aluZero patterns
    for (int k = 0; k < 80; k++) begin
      if (state == 4'd0) opcode = ops[retired % 4];
      memReady = (k % 3) != 1;
      aluZero = k[0];
      tick();
    end
    memReady = 1;
    run_until(4'd0);

    // Illegal opcode halts until reset
    opcode = 7'b1111111;
    tick(); tick();
    chk("halt_state", 32'(state), 9);
    chk("halt_flag", 32'(halted), 1);
    saved = retired;
    for (int k = 0; k < 20; k++) begin
      memReady = k[0];
      tick();
    end
    chk("halt_retired", retired, saved);
    chk("halt_stuck", 32'(state), 9);
    reset = 1; #1;
    chk("halt_rst_state", 32'(state), 0);
    chk("halt_rst_flag", 32'(halted), 0);
    tick(); reset = 0; memReady = 1;

    // Asynchronous reset in the middle of MEMWRITE
    opcode = OP_SW;
    tick(); tick(); tick();
    memReady = 0;
    chk("ar_pre_memwrite", 32'(memWrite), 1);
    #2 reset = 1;
    #1;
    chk("ar_memwrite", 32'(memWrite), 0);
    chk("ar_state", 32'(state), 0);
    chk("ar_retired", retired, 0);
    tick(); reset = 0; memReady = 1;
    opcode = OP_I;
    repeat (4) tick();
    chk("ar_after_retired", retired, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
